// File: rtl/hazard_stall_controller.sv
// ID-stage hazard and mul/div sequencing controller: stall/flush/bubble are combinational (zero latency),
// MD_Start/MD_IsDiv are registered one cycle after issue; load-use or HI/LO interlock holds PC and IF/ID.
module hazard_stall_controller #(
  parameter int MULT_LATENCY = 4,
  parameter int DIV_LATENCY  = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] ID_Instruction,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_RegisterRt,
  input  logic        ID_BranchTaken,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        MD_Start,
  output logic        MD_IsDiv,
  output logic        MD_Busy,
  output logic [31:0] StallCount
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [5:0] MULT_CNT = 6'(MULT_LATENCY);
  localparam logic [5:0] DIV_CNT  = 6'(DIV_LATENCY);

  state_t      state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic        rst_done;
  logic        md_start, md_isdiv;
  logic [31:0] stall_count;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt;
  logic        md_op, md_div, hilo_rd;
  logic        load_use, md_stall, stall, issue;
  logic        unused_instr_bits;

  assign opcode = ID_Instruction[31:26];
  assign rs     = ID_Instruction[25:21];
  assign rt     = ID_Instruction[20:16];
  assign funct  = ID_Instruction[5:0];
  assign unused_instr_bits = ^ID_Instruction[15:6];

  assign md_op   = (opcode == 6'b000000) && (funct[5:2] == 4'b0110);
  assign md_div  = md_op && funct[1];
  assign hilo_rd = (opcode == 6'b000000) &&
                   ((funct == 6'b010000) || (funct == 6'b010010));

  assign load_use = EX_MemRead && (EX_RegisterRt != 5'd0) &&
                    ((EX_RegisterRt == rs) || (EX_RegisterRt == rt));
  assign md_stall = MD_Busy && (md_op || hilo_rd);
  assign stall    = load_use || md_stall;

  // rst_done stays low until the first rising edge after Reset releases,
  // so the pipeline is held frozen for the whole reset window.
  assign issue = rst_done && (state == RUN) && md_op && !stall;

  assign MD_Busy    = (state == MD_BUSY);
  assign MD_Start   = md_start;
  assign MD_IsDiv   = md_isdiv;
  assign StallCount = stall_count;

  always_comb begin
    PCWrite      = 1'b0;
    IF_ID_Write  = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b1;
    if (rst_done && !stall) begin
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      IF_ID_Flush  = ID_BranchTaken;
      ID_EX_Bubble = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (issue) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = md_div ? DIV_CNT : MULT_CNT;
        end
      end
      MD_BUSY: begin
        // A waiting MD op is always stalled while busy, so it never issues here.
        if (cnt == 6'd1) begin
          state_nxt = RUN;
          cnt_nxt   = 6'd0;
        end else begin
          cnt_nxt = cnt - 6'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= RUN;
      cnt         <= 6'd0;
      rst_done    <= 1'b0;
      md_start    <= 1'b0;
      md_isdiv    <= 1'b0;
      stall_count <= 32'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rst_done <= 1'b1;
      md_start <= issue;
      md_isdiv <= issue && md_div;
      if (rst_done && stall && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomized + directed bench for hazard_stall_controller; per-cycle expected outputs
// come from a cycle-number based reference model and are checked by a separate monitor.
module tb_hazard_stall_controller;

  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        mem_read = 1'b0;
  logic [4:0]  ex_rt = 5'd0;
  logic        br = 1'b0;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic        md_start, md_isdiv, md_busy;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  hazard_stall_controller #(.MULT_LATENCY(MULT_LAT), .DIV_LATENCY(DIV_LAT)) dut (
    .Clk(clk), .Reset(reset_n), .ID_Instruction(instr), .EX_MemRead(mem_read),
    .EX_RegisterRt(ex_rt), .ID_BranchTaken(br), .PCWrite(pc_write),
    .IF_ID_Write(if_id_write), .IF_ID_Flush(if_id_flush), .ID_EX_Bubble(id_ex_bubble),
    .MD_Start(md_start), .MD_IsDiv(md_isdiv), .MD_Busy(md_busy), .StallCount(stall_count)
  );

  // {pcw, ifw, flush, bubble, start, isdiv, busy, count}
  logic [38:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the mul/div unit is described by the cycle of its last busy
  // cycle and the cycle in which its start pulse is due.
  longint      cyc = 0;
  longint      busy_end = -1;
  longint      start_cyc = -1;
  bit          start_div = 1'b0;
  logic [31:0] m_cnt = 32'd0;
  bit          prev_rst = 1'b0;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    rtype = {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt);
    itype = {op, 5'(rs), 5'(rt), 16'h1234};
  endfunction

  localparam logic [5:0] F_ADD = 6'b100000, F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV = 6'b011010, F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010;

  task automatic step(input logic [31:0] ins, input logic mr, input logic [4:0] ert,
                      input logic b, input logic rn);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt;
    bit          mdop, isdiv, hilo, busy, lu, st;
    logic [38:0] e;
    @(negedge clk);
    instr = ins; mem_read = mr; ex_rt = ert; br = b; reset_n = rn;
    op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16];
    mdop  = (op == 6'd0) && (fn == F_MULT || fn == F_MULTU || fn == F_DIV || fn == F_DIVU);
    isdiv = mdop && (fn == F_DIV || fn == F_DIVU);
    hilo  = (op == 6'd0) && (fn == F_MFHI || fn == F_MFLO);
    if (!(rn && prev_rst)) begin
      busy_end = -1; start_cyc = -1; m_cnt = 32'd0;
      e = {4'b0001, 3'b000, 32'd0};
    end else begin
      busy = (cyc <= busy_end);
      lu   = mr && (ert != 5'd0) && (ert == rs || ert == rt);
      st   = lu || (busy && (mdop || hilo));
      e = {!st, !st, !st && b, st, cyc == start_cyc, (cyc == start_cyc) && start_div, busy, m_cnt};
      if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (!busy && mdop && !st) begin
        busy_end  = cyc + (isdiv ? DIV_LAT : MULT_LAT);
        start_cyc = cyc + 1;
        start_div = isdiv;
      end
    end
    exp_q.push_back(e);
    prev_rst = rn;
    cyc++;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(32'd0, 1'b0, 5'd0, 1'b0, 1'b1);
  endtask

  // Monitor: every cycle the DUT presents a full output set, compared mid-cycle.
  initial begin : monitor
    logic [38:0] a, e;
    int mcyc;
    mcyc = 0;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {pc_write, if_id_write, if_id_flush, id_ex_bubble, md_start, md_isdiv, md_busy, stall_count};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL cycle_%0d outputs: got pcw,ifw,flush,bub,start,isdiv,busy=%b count=%h, want %b count=%h",
                   mcyc, a[38:32], a[31:0], e[38:32], e[31:0]);
        end
        mcyc++;
      end
    end
  end

  initial begin : driver
    int r, wait_n;
    // reset and release
    step(32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step(32'd0, 1'b1, 5'd0, 1'b1, 1'b0);
    step(32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step(32'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    nop(2);
    // load-use: add $9,$8,$10 behind lw $8, then rt=0 variant
    step(rtype(8, 10, 9, F_ADD), 1'b1, 5'd8, 1'b0, 1'b1);
    step(rtype(8, 10, 9, F_ADD), 1'b0, 5'd0, 1'b0, 1'b1);
    step(rtype(0, 10, 9, F_ADD), 1'b1, 5'd0, 1'b0, 1'b1);
    step(rtype(10, 8, 9, F_ADD), 1'b1, 5'd8, 1'b0, 1'b1);
    nop(1);
    // mult then mflo held until the unit frees
    step(rtype(8, 9, 0, F_MULT), 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(rtype(0, 0, 10, F_MFLO), 1'b0, 5'd0, 1'b0, 1'b1);
    nop(2);
    // div then divu back-to-back
    step(rtype(8, 9, 0, F_DIV), 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 33; i++) step(rtype(8, 9, 0, F_DIVU), 1'b0, 5'd0, 1'b0, 1'b1);
    nop(2);
    // wait out the divu
    nop(32);
    // branch taken while load-use stalls
    step(rtype(8, 10, 9, F_ADD), 1'b1, 5'd8, 1'b1, 1'b1);
    step(rtype(8, 10, 9, F_ADD), 1'b0, 5'd0, 1'b1, 1'b1);
    nop(1);
    // reset in the middle of a divide
    step(rtype(8, 9, 0, F_DIV), 1'b0, 5'd0, 1'b0, 1'b1);
    nop(22);
    step(rtype(0, 0, 10, F_MFLO), 1'b1, 5'd0, 1'b1, 1'b0);
    step(rtype(0, 0, 10, F_MFLO), 1'b0, 5'd0, 1'b0, 1'b0);
    step(rtype(0, 0, 10, F_MFLO), 1'b0, 5'd0, 1'b0, 1'b1);
    step(rtype(0, 0, 10, F_MFLO), 1'b0, 5'd0, 1'b0, 1'b1);
    // saturation: preload the counter in a non-stall cycle, then stall 4 cycles
    nop(1);
    #3;
    force dut.stall_count = 32'hFFFF_FFFD;
    #1;
    release dut.stall_count;
    m_cnt = 32'hFFFF_FFFD;
    for (int i = 0; i < 4; i++) step(rtype(8, 10, 9, F_ADD), 1'b1, 5'd8, 1'b0, 1'b1);
    nop(2);
    step(32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step(32'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] ins;
      logic [5:0]  fns[4];
      fns[0] = F_MULT; fns[1] = F_MULTU; fns[2] = F_DIV; fns[3] = F_DIVU;
      r = $urandom_range(0, 99);
      if (r < 10)      ins = rtype($urandom_range(0, 7), $urandom_range(0, 7), 0, fns[$urandom_range(0, 3)]);
      else if (r < 25) ins = rtype(0, 0, $urandom_range(1, 7), ($urandom_range(0, 1) == 1) ? F_MFHI : F_MFLO);
      else if (r < 55) ins = rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), F_ADD);
      else if (r < 70) ins = itype(6'b100011, $urandom_range(0, 7), $urandom_range(0, 7));
      else             ins = $urandom;
      step(ins, ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) != 0));
    end
    nop(2);
    wait_n = 0;
    while (exp_q.size() > 0 && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    #4;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected cycles never compared, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
